// File: rtl/video_pattern_gen.sv
// Raster timing generator with selectable test patterns (solid, colour bars, ramp, checker).
// Produces a registered vsync/hsync/de/data stream and always finishes the frame in progress before idling.
module video_pattern_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter int W_DATA   = 24,
    parameter int BAR_LOG2 = 8,
    parameter int CHK_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        pat_sel,
    input  logic [W_DATA-1:0] solid_color,
    output logic              vsync,
    output logic              hsync,
    output logic              de,
    output logic [W_DATA-1:0] data,
    output logic              frame_start,
    output logic              busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t            state;
    logic [HW-1:0]     hcnt_p0;
    logic [VW-1:0]     vcnt_p0;
    logic [1:0]        pat_q;
    logic [W_DATA-1:0] solid_q;
    logic [7:0]        frame_cnt;

    logic              de_p1, hsync_p1, vsync_p1, fs_p1, busy_p1;
    logic [W_DATA-1:0] data_p1;

    logic              issue, h_last, v_last, frame_last, first;
    logic              act, hs, vs;
    logic [1:0]        pat_cur;
    logic [W_DATA-1:0] solid_cur, pix;

    function automatic logic [W_DATA-1:0] bar_color(input logic [2:0] bar);
        logic [23:0] c;
        case (bar)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return W_DATA'(c);
    endfunction

    function automatic logic [W_DATA-1:0] pattern(input logic [1:0] sel,
                                                  input logic [W_DATA-1:0] solid,
                                                  input logic [15:0] x,
                                                  input logic [15:0] y,
                                                  input logic [7:0] fc);
        logic [W_DATA-1:0] p;
        case (sel)
            2'd0:    p = solid;
            2'd1:    p = bar_color(3'(x >> BAR_LOG2));
            2'd2:    p = W_DATA'({3{x[7:0]}});
            default: p = ((((x >> CHK_LOG2) ^ (y >> CHK_LOG2) ^ 16'(fc)) & 16'd1) != 16'd0)
                         ? {W_DATA{1'b1}} : {W_DATA{1'b0}};
        endcase
        return p;
    endfunction

    always_comb begin
        issue      = (state != S_IDLE) || en;
        h_last     = (hcnt_p0 == HW'(H_TOTAL - 1));
        v_last     = (vcnt_p0 == VW'(V_TOTAL - 1));
        frame_last = h_last && v_last;
        first      = (hcnt_p0 == '0) && (vcnt_p0 == '0);
        // The first pixel uses the live selection, which is then held for the frame.
        pat_cur    = first ? pat_sel : pat_q;
        solid_cur  = first ? solid_color : solid_q;
        act        = (hcnt_p0 < HW'(H_ACTIVE)) && (vcnt_p0 < VW'(V_ACTIVE));
        hs         = (hcnt_p0 >= HW'(H_ACTIVE + H_FP)) && (hcnt_p0 < HW'(H_ACTIVE + H_FP + H_SYNC));
        vs         = (vcnt_p0 >= VW'(V_ACTIVE + V_FP)) && (vcnt_p0 < VW'(V_ACTIVE + V_FP + V_SYNC));
        pix        = act ? pattern(pat_cur, solid_cur, 16'(hcnt_p0), 16'(vcnt_p0), frame_cnt) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            hcnt_p0   <= '0;
            vcnt_p0   <= '0;
            pat_q     <= '0;
            solid_q   <= '0;
            frame_cnt <= '0;
            de_p1     <= 1'b0;
            hsync_p1  <= 1'b0;
            vsync_p1  <= 1'b0;
            fs_p1     <= 1'b0;
            busy_p1   <= 1'b0;
            data_p1   <= '0;
        end else begin
            // p0 -> p1: decode the issued counter value into the registered stream
            busy_p1  <= issue;
            de_p1    <= issue && act;
            hsync_p1 <= issue && hs;
            vsync_p1 <= issue && vs;
            fs_p1    <= issue && first;
            data_p1  <= issue ? pix : '0;

            if (issue) begin
                if (first) begin
                    pat_q   <= pat_sel;
                    solid_q <= solid_color;
                end
                if (h_last) begin
                    hcnt_p0 <= '0;
                    vcnt_p0 <= v_last ? '0 : vcnt_p0 + 1'b1;
                end else begin
                    hcnt_p0 <= hcnt_p0 + 1'b1;
                end
                if (frame_last)
                    frame_cnt <= frame_cnt + 8'd1;
            end else begin
                hcnt_p0 <= '0;
                vcnt_p0 <= '0;
            end

            case (state)
                S_IDLE:  if (en) state <= S_RUN;
                S_RUN:   if (!en) state <= frame_last ? S_IDLE : S_DRAIN;
                S_DRAIN: begin
                    if (en)              state <= S_RUN;
                    else if (frame_last) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign vsync       = vsync_p1;
    assign hsync       = hsync_p1;
    assign de          = de_p1;
    assign data        = data_p1;
    assign frame_start = fs_p1;
    assign busy        = busy_p1;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a 14x7 raster (98 clks per frame).
module tb_video_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  pat_sel = 2'd0;
    logic [23:0] solid_color = 24'h123456;
    logic        vsync, hsync, de, frame_start, busy;
    logic [23:0] data;

    int n_cmp = 0;
    int n_fail = 0;
    int pos = 0;

    video_pattern_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .W_DATA(24), .BAR_LOG2(0), .CHK_LOG2(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pat_sel(pat_sel), .solid_color(solid_color),
        .vsync(vsync), .hsync(hsync), .de(de), .data(data),
        .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; observations are taken 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        pos = (pos + 1) % 98;
    endtask

    task automatic goto(input int target);
        for (int i = 0; i < 98 && pos != target; i++) step();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " de"}, de, 1'b0);
        chk({tag, " hsync"}, hsync, 1'b0);
        chk({tag, " vsync"}, vsync, 1'b0);
        chk({tag, " fs"}, frame_start, 1'b0);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " data"}, data, 24'h0);
    endtask

    initial begin
        int h, v;
        logic e_de, e_hs, e_vs;

        // Reset state
        step();
        step();
        chk_idle("reset");

        // Test 1: solid colour, full frame timing
        rst = 1'b0;
        en  = 1'b1;
        step();
        pos = 0;
        for (int k = 0; k < 98; k++) begin
            if (k > 0) step();
            h = k % 14;
            v = k / 14;
            e_de = (h < 8) && (v < 4);
            e_hs = (h >= 10) && (h < 12);
            e_vs = (v == 5);
            chk($sformatf("t1 de k%0d", k), de, e_de);
            chk($sformatf("t1 hsync k%0d", k), hsync, e_hs);
            chk($sformatf("t1 vsync k%0d", k), vsync, e_vs);
            chk($sformatf("t1 fs k%0d", k), frame_start, (k == 0));
            chk($sformatf("t1 data k%0d", k), data, e_de ? 24'h123456 : 24'h0);
            chk($sformatf("t1 busy k%0d", k), busy, 1'b1);
        end

        // Test 2: colour bars from the next frame (period 98)
        pat_sel = 2'd1;
        step();
        chk("t2 period fs", frame_start, 1'b1);
        chk("t2 bar0", data, 24'hFFFFFF);
        step(); chk("t2 bar1", data, 24'hFFFF00);
        step(); chk("t2 bar2", data, 24'h00FFFF);
        step(); chk("t2 bar3", data, 24'h00FF00);
        step(); chk("t2 bar4", data, 24'hFF00FF);
        step(); chk("t2 bar5", data, 24'hFF0000);
        step(); chk("t2 bar6", data, 24'h0000FF);
        step(); chk("t2 bar7", data, 24'h000000);
        chk("t2 de at x7", de, 1'b1);

        // Test 4: mid-frame change to ramp only applies at next frame
        pat_sel = 2'd2;
        step(); chk("t4 blank data", data, 24'h0);
        goto(14); chk("t4 held bar0", data, 24'hFFFFFF);
        step();   chk("t4 held bar1", data, 24'hFFFF00);
        goto(0);
        chk("t4 ramp fs", frame_start, 1'b1);
        chk("t4 ramp0", data, 24'h000000);
        step(); chk("t4 ramp1", data, 24'h010101);
        goto(7); chk("t4 ramp7", data, 24'h070707);

        // Test 3: drop en mid-frame, frame completes, then idle
        goto(30);
        en = 1'b0;
        goto(42); chk("t3 drain de", de, 1'b1);
        chk("t3 drain ramp", data, 24'h000000);
        goto(73); chk("t3 drain vsync", vsync, 1'b1);
        goto(97); chk("t3 last busy", busy, 1'b1);
        step();   chk_idle("t3 after");
        step(); step(); step();
        chk_idle("t3 held");
        en = 1'b1;
        step();
        pos = 0;
        chk("t3 restart fs", frame_start, 1'b1);
        chk("t3 restart busy", busy, 1'b1);

        // Test 6: reset mid-frame truncates immediately
        goto(50);
        rst = 1'b1;
        step();
        chk_idle("t6 reset");

        // Test 5: checker phase inverts each frame (frame_cnt restarted by reset)
        rst = 1'b0;
        pat_sel = 2'd3;
        step();
        pos = 0;
        chk("t6 restart fs", frame_start, 1'b1);
        chk("t5 f0 (0,0)", data, 24'h000000);
        step(); chk("t5 f0 (1,0)", data, 24'h000000);
        step(); chk("t5 f0 (2,0)", data, 24'hFFFFFF);
        goto(28); chk("t5 f0 (0,2)", data, 24'hFFFFFF);
        goto(0);
        chk("t5 f1 fs", frame_start, 1'b1);
        chk("t5 f1 (0,0)", data, 24'hFFFFFF);
        step(); step(); chk("t5 f1 (2,0)", data, 24'h000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
